// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch FSM state type and SRAM size encodings.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h1c00_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0280_0000;

    // Instruction fetch request FSM: at most one accepted request in flight.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } fetch_state_e;

    // SRAM-like port transfer size encodings.
    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/if_stage_if.sv
// SRAM-like instruction port: req/addr_ok address phase, data_ok data phase.
interface if_stage_if;
    import cpu_pkg::*;

    logic            req;
    logic            wr;
    logic [1:0]      size;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] addr;
    logic            addr_ok;
    logic [XLEN-1:0] rdata;
    logic            data_ok;

    modport master (
        output req, wr, size, wstrb, wdata, addr,
        input  addr_ok, rdata, data_ok
    );

    modport slave (
        input  req, wr, size, wstrb, wdata, addr,
        output addr_ok, rdata, data_ok
    );

endinterface

// File: rtl/if_redirect_sel.sv
// Priority select of PC redirect sources: exception > ertn > branch.
module if_redirect_sel
    import cpu_pkg::*;
(
    input  logic            wb_ex,
    input  logic [XLEN-1:0] ex_entry,
    input  logic            wb_is_ertn,
    input  logic [XLEN-1:0] ertn_pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_target
);

    // Highest-priority active source wins the target.
    always_comb begin
        redir_valid  = wb_ex | wb_is_ertn | br_taken;
        redir_target = br_target;
        if (wb_ex) begin
            redir_target = ex_entry;
        end else if (wb_is_ertn) begin
            redir_target = ertn_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, one-outstanding SRAM fetch,
// single-entry instruction slot toward ID, redirect and stale-data discard.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_allow_in,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               wb_ex,
    input  logic [31:0]        ex_entry,
    input  logic               wb_is_ertn,
    input  logic [31:0]        ertn_pc,
    if_stage_if.master         inst_sram,
    output logic               if_ready_go,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst
);

    fetch_state_e state_q, state_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic [31:0]  last_req_pc_q, last_req_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic         discard_q, discard_d;
    logic         discard_next_q, discard_next_d;
    logic         hold_q, hold_d;
    logic [31:0]  hold_addr_q, hold_addr_d;

    logic         redir_valid;
    logic [31:0]  redir_target;
    logic         consume_c;
    logic         req_c;
    logic [31:0]  addr_c;
    logic         acc_c;
    logic         rsp_c;

    if_redirect_sel u_redirect_sel (
        .wb_ex        (wb_ex),
        .ex_entry     (ex_entry),
        .wb_is_ertn   (wb_is_ertn),
        .ertn_pc      (ertn_pc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .redir_valid  (redir_valid),
        .redir_target (redir_target)
    );

    // Request/handshake decode; an unaccepted request is frozen in hold_addr.
    always_comb begin
        consume_c = if_valid_q & id_allow_in;
        req_c     = (state_q == IDLE) & (hold_q | ~if_valid_q | consume_c);
        addr_c    = hold_q       ? hold_addr_q :
                    redir_pend_q ? redir_pc_q  : last_req_pc_q + 32'd4;
        acc_c     = req_c & inst_sram.addr_ok;
        rsp_c     = (state_q == WAIT_DATA) & inst_sram.data_ok;
    end

    // Next-state for FSM, PC tracking, instruction slot and discard bookkeeping.
    always_comb begin
        state_d        = state_q;
        redir_pend_d   = redir_pend_q;
        redir_pc_d     = redir_pc_q;
        last_req_pc_d  = last_req_pc_q;
        if_valid_d     = if_valid_q;
        if_pc_d        = if_pc_q;
        if_inst_d      = if_inst_q;
        discard_d      = discard_q;
        discard_next_d = discard_next_q;
        hold_d         = hold_q;
        hold_addr_d    = hold_addr_q;

        if (acc_c) begin
            state_d = WAIT_DATA;
        end else if (rsp_c) begin
            state_d = IDLE;
        end

        // Address phase: a stale held request must not consume the pending redirect.
        if (acc_c) begin
            last_req_pc_d  = addr_c;
            hold_d         = 1'b0;
            discard_next_d = 1'b0;
            if (discard_next_q) begin
                discard_d = 1'b1;
            end else begin
                redir_pend_d = 1'b0;
            end
        end else if (req_c) begin
            hold_d      = 1'b1;
            hold_addr_d = addr_c;
        end

        // Data phase: capture wins over consumption in the same cycle.
        if (rsp_c) begin
            if (discard_q) begin
                discard_d = 1'b0;
            end else begin
                if_inst_d  = inst_sram.rdata;
                if_pc_d    = last_req_pc_q;
                if_valid_d = 1'b1;
            end
        end else if (consume_c) begin
            if_valid_d = 1'b0;
        end

        // Redirect: flush slot, drop same-cycle data, mark in-flight work stale.
        if (redir_valid) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = redir_target;
            if_valid_d   = 1'b0;
            if_pc_d      = if_pc_q;
            if_inst_d    = if_inst_q;
            if (((state_q == WAIT_DATA) && !inst_sram.data_ok) || acc_c) begin
                discard_d = 1'b1;
            end
            if (req_c && !inst_sram.addr_ok) begin
                discard_next_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            redir_pend_q   <= 1'b1;
            redir_pc_q     <= RESET_PC;
            last_req_pc_q  <= RESET_PC - 32'd4;
            if_valid_q     <= 1'b0;
            if_pc_q        <= 32'h1bff_fffc;
            if_inst_q      <= NOP_INST;
            discard_q      <= 1'b0;
            discard_next_q <= 1'b0;
            hold_q         <= 1'b0;
            hold_addr_q    <= RESET_PC;
        end else begin
            state_q        <= state_d;
            redir_pend_q   <= redir_pend_d;
            redir_pc_q     <= redir_pc_d;
            last_req_pc_q  <= last_req_pc_d;
            if_valid_q     <= if_valid_d;
            if_pc_q        <= if_pc_d;
            if_inst_q      <= if_inst_d;
            discard_q      <= discard_d;
            discard_next_q <= discard_next_d;
            hold_q         <= hold_d;
            hold_addr_q    <= hold_addr_d;
        end
    end

    // Port drive: read-only word fetches.
    always_comb begin
        inst_sram.req   = req_c;
        inst_sram.addr  = addr_c;
        inst_sram.wr    = 1'b0;
        inst_sram.size  = SRAM_SIZE_WORD;
        inst_sram.wstrb = 4'd0;
        inst_sram.wdata = 32'd0;
        if_ready_go     = if_valid_q;
        if_pc           = if_pc_q;
        if_inst         = if_valid_q ? if_inst_q : NOP_INST;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed cycle-by-cycle bench for if_stage.
module tb_if_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_allow_in;
    logic        br_taken, wb_ex, wb_is_ertn;
    logic [31:0] br_target, ex_entry, ertn_pc;
    logic        if_ready_go;
    logic [31:0] if_pc, if_inst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage_if sram ();

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .id_allow_in (id_allow_in),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .wb_ex       (wb_ex),
        .ex_entry    (ex_entry),
        .wb_is_ertn  (wb_is_ertn),
        .ertn_pc     (ertn_pc),
        .inst_sram   (sram),
        .if_ready_go (if_ready_go),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    typedef struct {
        logic        allow, aok, dok;
        logic [31:0] rdata;
        logic        br, ex, er;
        logic [31:0] brt, exe, erpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_rdy;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tv[$];
    vec_t v;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic allow, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [31:0] e_addr, input logic e_rdy,
                                input logic [31:0] e_pc);
        vec_t r;
        r.allow = allow; r.aok = aok; r.dok = dok; r.rdata = rdata;
        r.br = 1'b0; r.ex = 1'b0; r.er = 1'b0;
        r.brt = 32'd0; r.exe = 32'd0; r.erpc = 32'd0;
        r.e_req = e_req; r.e_addr = e_addr; r.e_rdy = e_rdy; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        id_allow_in        = x.allow;
        sram.addr_ok       = x.aok;
        sram.data_ok       = x.dok;
        sram.rdata         = x.rdata;
        br_taken           = x.br;
        br_target          = x.brt;
        wb_ex              = x.ex;
        ex_entry           = x.exe;
        wb_is_ertn         = x.er;
        ertn_pc            = x.erpc;
    endtask

    task automatic check(input vec_t x, input string tag);
        chk32({tag, " req"}, 32'(sram.req), 32'(x.e_req));
        if (x.e_req) chk32({tag, " addr"}, sram.addr, x.e_addr);
        chk32({tag, " ready_go"}, 32'(if_ready_go), 32'(x.e_rdy));
        if (x.e_rdy) chk32({tag, " if_pc"}, if_pc, x.e_pc);
        chk32({tag, " if_inst"}, if_inst, x.e_rdy ? inst_of(x.e_pc) : NOP_INST);
    endtask

    // Drive just after posedge, check on negedge, advance to next cycle.
    task automatic step(input vec_t x, input string tag);
        apply(x);
        @(negedge clk);
        check(x, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk32({tag, " req"}, 32'(sram.req), 32'd1);
        chk32({tag, " addr"}, sram.addr, 32'h1c00_0000);
        chk32({tag, " ready_go"}, 32'(if_ready_go), 32'd0);
        chk32({tag, " if_pc"}, if_pc, 32'h1bff_fffc);
        chk32({tag, " if_inst"}, if_inst, 32'h0280_0000);
        chk32({tag, " wr"}, 32'(sram.wr), 32'd0);
        chk32({tag, " size"}, 32'(sram.size), 32'd2);
        chk32({tag, " wstrb"}, 32'(sram.wstrb), 32'd0);
        chk32({tag, " wdata"}, sram.wdata, 32'd0);
    endtask

    initial begin
        // Sequential fetch with zero-latency addr_ok and next-cycle data_ok.
        tv.push_back(mk(1, 1, 0, 0, 1, 32'h1c00_0000, 0, 0));
        tv.push_back(mk(1, 1, 1, inst_of(32'h1c00_0000), 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 32'h1c00_0004, 1, 32'h1c00_0000));
        tv.push_back(mk(1, 1, 1, inst_of(32'h1c00_0004), 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 32'h1c00_0008, 1, 32'h1c00_0004));
        tv.push_back(mk(1, 1, 1, inst_of(32'h1c00_0008), 0, 0, 0, 0));
        // ID stalls five cycles: slot held, no request.
        for (int i = 0; i < 5; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1c00_0008));
        // Release: next request at if_pc+4 in the same cycle.
        tv.push_back(mk(1, 1, 0, 0, 1, 32'h1c00_000c, 1, 32'h1c00_0008));
        // Branch while waiting for data: stale response dropped.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0); v.br = 1; v.brt = 32'h1c00_0100; tv.push_back(v);
        tv.push_back(mk(1, 0, 1, inst_of(32'h1c00_000c), 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 32'h1c00_0100, 0, 0));
        tv.push_back(mk(1, 1, 1, inst_of(32'h1c00_0100), 0, 0, 0, 0));
        // Exception and branch together, coinciding with addr_ok: exception wins.
        v = mk(1, 1, 0, 0, 1, 32'h1c00_0104, 1, 32'h1c00_0100);
        v.ex = 1; v.exe = 32'h1c00_8000; v.br = 1; v.brt = 32'h1c00_0200; tv.push_back(v);
        tv.push_back(mk(1, 0, 1, inst_of(32'h1c00_0104), 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 32'h1c00_8000, 0, 0));
        tv.push_back(mk(1, 0, 1, inst_of(32'h1c00_8000), 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1c00_8000));

        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) step(tv[i], $sformatf("vec%0d", i));

        // ertn while a request waits for addr_ok: address frozen, data discarded.
        step(mk(1, 0, 0, 0, 1, 32'h1c00_8004, 1, 32'h1c00_8000), "ertn0");
        v = mk(1, 0, 0, 0, 1, 32'h1c00_8004, 0, 0); v.er = 1; v.erpc = 32'h1c00_0040;
        step(v, "ertn1");
        step(mk(1, 0, 0, 0, 1, 32'h1c00_8004, 0, 0), "ertn2");
        step(mk(1, 1, 0, 0, 1, 32'h1c00_8004, 0, 0), "ertn3");
        step(mk(1, 0, 1, inst_of(32'h1c00_8004), 0, 0, 0, 0), "ertn4");
        step(mk(1, 0, 0, 0, 1, 32'h1c00_0040, 0, 0), "ertn5");
        step(mk(1, 1, 0, 0, 1, 32'h1c00_0040, 0, 0), "ertn6");
        step(mk(1, 0, 1, inst_of(32'h1c00_0040), 0, 0, 0, 0), "ertn7");

        // Capture then immediate consumption with next request issued alongside.
        step(mk(1, 0, 0, 0, 1, 32'h1c00_0044, 1, 32'h1c00_0040), "cons0");
        step(mk(1, 1, 0, 0, 1, 32'h1c00_0044, 0, 0), "cons1");
        step(mk(1, 0, 1, inst_of(32'h1c00_0044), 0, 0, 0, 0), "cons2");
        step(mk(1, 1, 0, 0, 1, 32'h1c00_0048, 1, 32'h1c00_0044), "cons3");

        // Reset while a request is outstanding; its data never returns.
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst_wait");
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
